// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_pkg
// Description : Shared constants and FSM encodings for the program counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_unit_pkg;

    localparam int unsigned c_MEM_ADDR_WIDTH  = 10;
    localparam int unsigned c_RESET_VECTOR    = 32'h0000_0000;
    localparam int unsigned c_TRAP_VECTOR     = 32'h0000_0100;
    localparam int unsigned c_ILEN_BYTES      = 4;

    localparam int unsigned c_STATE_W         = 2;
    localparam logic [c_STATE_W-1:0] c_ST_BOOT = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_RUN  = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT = 2'd2;

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_calc
// Description : Combinational next-PC selection and target alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_calc
    import pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = c_MEM_ADDR_WIDTH,
    parameter int unsigned TRAP_VECTOR = c_TRAP_VECTOR,
    parameter int unsigned ILEN_BYTES  = c_ILEN_BYTES
) (
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [ADDR_WIDTH-1:0] i_target,
    input  logic [ADDR_WIDTH-1:0] i_epc,
    input  logic                  i_trap,
    input  logic                  i_mret,
    input  logic                  i_advance,
    input  logic                  i_absolute,
    input  logic                  i_branch,
    output logic [ADDR_WIDTH-1:0] o_next_pc,
    output logic                  o_misaligned
);

    localparam logic [ADDR_WIDTH-1:0] c_TRAP_PC    = ADDR_WIDTH'(TRAP_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] c_ILEN       = ADDR_WIDTH'(ILEN_BYTES);
    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ADDR_WIDTH'(ILEN_BYTES - 1);

    logic [ADDR_WIDTH-1:0] w_jump_tgt;
    logic [ADDR_WIDTH-1:0] w_branch_tgt;
    logic [ADDR_WIDTH-1:0] w_seq_pc;

    assign w_jump_tgt   = {i_target[ADDR_WIDTH-1:1], 1'b0};
    assign w_branch_tgt = i_pc + i_target;
    assign w_seq_pc     = i_pc + c_ILEN;

    // A misaligned redirect leaves the PC in place; the core answers with a trap.
    always_comb begin
        o_next_pc    = i_pc;
        o_misaligned = 1'b0;
        if (i_trap) begin
            o_next_pc = c_TRAP_PC;
        end else if (i_mret) begin
            o_next_pc = i_epc;
        end else if (i_advance) begin
            if (i_absolute) begin
                if ((w_jump_tgt & c_ALIGN_MASK) != '0) begin
                    o_misaligned = 1'b1;
                end else begin
                    o_next_pc = w_jump_tgt;
                end
            end else if (i_branch) begin
                if ((w_branch_tgt & c_ALIGN_MASK) != '0) begin
                    o_misaligned = 1'b1;
                end else begin
                    o_next_pc = w_branch_tgt;
                end
            end else begin
                o_next_pc = w_seq_pc;
            end
        end
    end

endmodule : pc_next_calc
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : RV32I program counter with fetch handshake, traps and EPC.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = c_MEM_ADDR_WIDTH,
    parameter int unsigned RESET_VECTOR = c_RESET_VECTOR,
    parameter int unsigned TRAP_VECTOR  = c_TRAP_VECTOR,
    parameter int unsigned ILEN_BYTES   = c_ILEN_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  branch_i,
    input  logic                  absolute_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    input  logic                  trap_i,
    input  logic                  mret_i,
    input  logic                  fetch_ready_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  fetch_valid_o,
    output logic [ADDR_WIDTH-1:0] link_o,
    output logic [ADDR_WIDTH-1:0] epc_o,
    output logic                  misaligned_o
);

    localparam logic [ADDR_WIDTH-1:0] c_RST_PC = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] c_ILEN   = ADDR_WIDTH'(ILEN_BYTES);

    logic [c_STATE_W-1:0]  r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_epc;
    logic                  r_fetch_valid;
    logic                  r_misaligned;

    logic                  w_advance;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic                  w_misaligned;

    assign w_advance = (r_state != c_ST_BOOT) && !stall_i && r_fetch_valid && fetch_ready_i;

    pc_next_calc #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .TRAP_VECTOR (TRAP_VECTOR),
        .ILEN_BYTES  (ILEN_BYTES)
    ) u_next (
        .i_pc         (r_pc),
        .i_target     (target_i),
        .i_epc        (r_epc),
        .i_trap       (trap_i),
        .i_mret       (mret_i),
        .i_advance    (w_advance),
        .i_absolute   (absolute_i),
        .i_branch     (branch_i),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_BOOT;
            r_pc          <= c_RST_PC;
            r_epc         <= '0;
            r_fetch_valid <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_pc         <= w_next_pc;
            r_misaligned <= w_misaligned;
            if (trap_i) begin
                r_epc <= r_pc;
            end
            case (r_state)
                c_ST_BOOT: begin
                    r_state       <= c_ST_RUN;
                    r_fetch_valid <= 1'b1;
                end
                c_ST_RUN: begin
                    r_fetch_valid <= 1'b1;
                    if (!(trap_i || mret_i) && (!fetch_ready_i || stall_i)) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    r_fetch_valid <= 1'b1;
                    if (trap_i || mret_i || w_advance) begin
                        r_state <= c_ST_RUN;
                    end
                end
                default: begin
                    r_state       <= c_ST_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o          = r_pc;
    assign fetch_valid_o = r_fetch_valid;
    assign link_o        = r_pc + c_ILEN;
    assign epc_o         = r_epc;
    assign misaligned_o  = r_misaligned;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    localparam int unsigned c_AW = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall_i;
    logic            branch_i;
    logic            absolute_i;
    logic [c_AW-1:0] target_i;
    logic            trap_i;
    logic            mret_i;
    logic            fetch_ready_i;
    logic [c_AW-1:0] pc_o;
    logic            fetch_valid_o;
    logic [c_AW-1:0] link_o;
    logic [c_AW-1:0] epc_o;
    logic            misaligned_o;

    int n_pass  = 0;
    int n_total = 0;

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .absolute_i    (absolute_i),
        .target_i      (target_i),
        .trap_i        (trap_i),
        .mret_i        (mret_i),
        .fetch_ready_i (fetch_ready_i),
        .pc_o          (pc_o),
        .fetch_valid_o (fetch_valid_o),
        .link_o        (link_o),
        .epc_o         (epc_o),
        .misaligned_o  (misaligned_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; branch_i = 1'b0; absolute_i = 1'b0;
        target_i = '0; trap_i = 1'b0; mret_i = 1'b0; fetch_ready_i = 1'b1;
        step(); step();
        check("reset_pc", pc_o, 32'h000);
        check("reset_valid", fetch_valid_o, 32'h0);
        check("reset_epc", epc_o, 32'h000);
        check("reset_mis", misaligned_o, 32'h0);

        // Boot bubble, then sequential free-run
        rst = 1'b0;
        step();
        check("boot_pc", pc_o, 32'h000);
        check("boot_valid", fetch_valid_o, 32'h1);
        check("boot_link", link_o, 32'h004);
        step(); check("seq_4", pc_o, 32'h004);
        step(); check("seq_8", pc_o, 32'h008);
        step(); check("seq_c", pc_o, 32'h00C);
        check("link_c", link_o, 32'h010);
        step(); check("seq_10", pc_o, 32'h010);

        // Backward branch by -8
        branch_i = 1'b1; target_i = 10'h3F8;
        step(); check("branch_back", pc_o, 32'h008);
        branch_i = 1'b0;

        // Jump to last word then wrap
        absolute_i = 1'b1; target_i = 10'h3FC;
        step(); check("jump_3fc", pc_o, 32'h3FC);
        check("link_wrap", link_o, 32'h000);
        absolute_i = 1'b0;
        step(); check("seq_wrap", pc_o, 32'h000);

        // JALR clears bit0; bit1 set is misaligned
        absolute_i = 1'b1; target_i = 10'h0A5;
        step(); check("jalr_a5", pc_o, 32'h0A4);
        check("jalr_a5_mis", misaligned_o, 32'h0);
        target_i = 10'h0A6;
        step(); check("jalr_a6_held", pc_o, 32'h0A4);
        check("jalr_a6_mis", misaligned_o, 32'h1);
        absolute_i = 1'b0;
        step(); check("mis_pulse_end", misaligned_o, 32'h0);
        check("seq_after_mis", pc_o, 32'h0A8);

        // Misaligned branch (pc 0xA8 + 2)
        branch_i = 1'b1; target_i = 10'h002;
        step(); check("br_mis_held", pc_o, 32'h0A8);
        check("br_mis", misaligned_o, 32'h1);
        branch_i = 1'b0;

        // Fetch back-pressure at 0x020
        absolute_i = 1'b1; target_i = 10'h020;
        step(); check("jump_20", pc_o, 32'h020);
        absolute_i = 1'b0; fetch_ready_i = 1'b0;
        step(); check("wait1_pc", pc_o, 32'h020);
        check("wait1_valid", fetch_valid_o, 32'h1);
        branch_i = 1'b1; target_i = 10'h040;
        step(); check("wait2_pc", pc_o, 32'h020);
        branch_i = 1'b0;
        step(); check("wait3_pc", pc_o, 32'h020);
        fetch_ready_i = 1'b1;
        step(); check("ready_pc", pc_o, 32'h024);

        // Stall holds the PC
        stall_i = 1'b1;
        step(); check("stall_pc", pc_o, 32'h024);
        stall_i = 1'b0;

        // Trap under stall, then mret
        absolute_i = 1'b1; target_i = 10'h040;
        step(); check("jump_40", pc_o, 32'h040);
        absolute_i = 1'b0; stall_i = 1'b1; trap_i = 1'b1;
        step(); check("trap_pc", pc_o, 32'h100);
        check("trap_epc", epc_o, 32'h040);
        trap_i = 1'b0; stall_i = 1'b0;
        step(); check("trap_seq", pc_o, 32'h104);
        mret_i = 1'b1;
        step(); check("mret_pc", pc_o, 32'h040);
        mret_i = 1'b0;
        step(); check("mret_seq", pc_o, 32'h044);
        trap_i = 1'b1; mret_i = 1'b1;
        step(); check("trap_mret_pc", pc_o, 32'h100);
        check("trap_mret_epc", epc_o, 32'h044);
        trap_i = 1'b0; mret_i = 1'b0;

        // Reset while in WAIT with a trap pending
        fetch_ready_i = 1'b0;
        step(); check("wait_pc", pc_o, 32'h100);
        rst = 1'b1; trap_i = 1'b1;
        step(); check("rst_pc", pc_o, 32'h000);
        check("rst_epc", epc_o, 32'h000);
        check("rst_valid", fetch_valid_o, 32'h0);
        rst = 1'b0; trap_i = 1'b0; fetch_ready_i = 1'b1;
        step(); check("rst_boot_pc", pc_o, 32'h000);
        check("rst_boot_valid", fetch_valid_o, 32'h1);
        step(); check("rst_seq", pc_o, 32'h004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pc_unit
`default_nettype wire
